arccotangent_search: RTL and testbench

//  Inverse of the cotangent LUT: takes an IEEE-754 double cotangent value and returns the integer angle in

---
 rtl/arccotangent_search_pkg.sv | 16 +
 rtl/arccotangent_search_if.sv | 13 +
 rtl/arccotangent_search_cot_rom.sv | 14 +
 rtl/arccotangent_search.sv | 75 +++++++
 tb/tb_arccotangent_search.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/arccotangent_search_pkg.sv
// arccotangent_search_pkg: shared widths, IEEE-754 constants, FSM states and cot table builder
package arccotangent_search_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ANGLE_MAX = 90;
  localparam int SEARCH_STEPS = 7;
  localparam logic [63:0] DFP_POS_INF = 64'h7FF0000000000000;
  localparam logic [63:0] DFP_ONE = 64'h3FF0000000000000;
  localparam logic [10:0] DFP_EXP_MAX = 11'h7FF;
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  // Elaboration-time only: pins the exact endpoints and 45 degrees, rounds the rest to nearest double.
  function automatic logic [63:0] cot_bits(input int k);
    real r;
    r = real'(k) * 3.14159265358979323846 / 180.0;
    return k == 0 ? DFP_POS_INF : k == 45 ? DFP_ONE : k >= ANGLE_MAX ? 64'd0 : $realtobits($cos(r) / $sin(r));
  endfunction
endpackage

// File: rtl/arccotangent_search_if.sv
// arccotangent_search_if: start/valid handshake and result bus of the arccotangent search
interface arccotangent_search_if;
  import arccotangent_search_pkg::*;
  logic en_arccotangent;
  logic [2*DATA_WIDTH-1:0] data_in;
  logic busy;
  logic valid;
  logic error;
  logic [1:0] quadrant;
  logic [DATA_WIDTH-1:0] angle_out;
  modport master (output en_arccotangent, data_in, input busy, valid, error, quadrant, angle_out);
  modport slave (input en_arccotangent, data_in, output busy, valid, error, quadrant, angle_out);
endinterface

// File: rtl/arccotangent_search_cot_rom.sv
// arccotangent_search_cot_rom: combinational angle -> cot(angle) double table, 0..ANGLE_MAX
module arccotangent_search_cot_rom
  import arccotangent_search_pkg::*;
(
  input  logic [6:0]  i_angle,
  output logic [63:0] o_cot
);
  logic [63:0] w_tbl [0:ANGLE_MAX];
  for (genvar k = 0; k <= ANGLE_MAX; k++) begin : g_tbl
    localparam logic [63:0] C = cot_bits(k);
    assign w_tbl[k] = C;
  end
  assign o_cot = i_angle <= 7'(ANGLE_MAX) ? w_tbl[i_angle] : 64'd0;
endmodule

// File: rtl/arccotangent_search.sv
// arccotangent_search: fixed-latency binary search of the cot table for the angle of a double
module arccotangent_search
  import arccotangent_search_pkg::*;
(
  input logic clk,
  input logic reset,
  arccotangent_search_if.slave bus
);
  state_t r_state, w_next;
  logic [62:0] r_mag;
  logic r_sign, r_nan, r_err;
  logic [6:0] r_lo, r_hi, w_lo, w_hi, w_mid;
  logic [2:0] r_cnt;
  logic [1:0] r_quad;
  logic [DATA_WIDTH-1:0] r_angle;
  logic [63:0] w_cot;
  logic w_accept, w_last, w_nan_in;
  assign w_accept = bus.en_arccotangent && r_state != SEARCH;
  assign w_last = r_state == SEARCH && r_cnt == 3'(SEARCH_STEPS - 1);
  assign w_nan_in = bus.data_in[62:52] == DFP_EXP_MAX && bus.data_in[51:0] != '0;
  assign w_mid = 7'((8'(r_lo) + 8'(r_hi)) >> 1);
  arccotangent_search_cot_rom u_rom (.i_angle(w_mid), .o_cot(w_cot));
  // Next state and one search step; magnitudes of non-negative doubles order as unsigned ints.
  always_comb begin
    w_next = r_state;
    w_lo = r_lo;
    w_hi = r_hi;
    if (w_accept) w_next = SEARCH;
    else if (w_last) w_next = DONE;
    else if (r_state == DONE) w_next = IDLE;
    if (r_lo < r_hi) begin
      if (w_cot <= {1'b0, r_mag}) w_hi = w_mid;
      else w_lo = w_mid + 7'd1;
    end
  end
  // State, operand latch, search bounds and registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_mag <= '0;
      r_sign <= 1'b0;
      r_nan <= 1'b0;
      r_lo <= '0;
      r_hi <= '0;
      r_cnt <= '0;
      r_angle <= '0;
      r_quad <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mag <= bus.data_in[62:0];
        r_sign <= bus.data_in[63];
        r_nan <= w_nan_in;
        r_lo <= '0;
        r_hi <= 7'(ANGLE_MAX);
        r_cnt <= '0;
      end else if (r_state == SEARCH) begin
        r_lo <= w_lo;
        r_hi <= w_hi;
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_last) begin
        r_angle <= r_nan ? '0 : DATA_WIDTH'(w_hi);
        r_quad <= {1'b0, r_sign && !r_nan && r_mag != '0};
        r_err <= r_nan;
      end
    end
  end
  assign bus.busy = r_state == SEARCH;
  assign bus.valid = r_state == DONE;
  assign bus.error = r_err;
  assign bus.quadrant = r_quad;
  assign bus.angle_out = r_angle;
endmodule

// File: tb/tb_arccotangent_search.sv
// tb_arccotangent_search: directed scoreboard bench for the arccotangent search
module tb_arccotangent_search;
  import arccotangent_search_pkg::*;
  typedef struct {
    logic [31:0] angle;
    logic [1:0]  quad;
    logic        err;
  } exp_t;
  localparam real PI = 3.14159265358979323846;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  exp_t sb[$];
  arccotangent_search_if bus();
  arccotangent_search dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input int a, input logic [1:0] q, input logic e);
    exp_t x;
    x.angle = 32'(a);
    x.quad = q;
    x.err = e;
    sb.push_back(x);
  endtask

  // Called at the falling edge after the accepting edge (or later, with lat reduced to match).
  task automatic wait_result(input string tag, input int lat);
    int n;
    exp_t x;
    n = 0;
    while (!bus.valid && n < 20) begin
      check({tag, " busy"}, 64'(bus.busy), 64'd1);
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    if (bus.valid && sb.size() > 0) begin
      x = sb.pop_front();
      check({tag, " angle"}, 64'(bus.angle_out), 64'(x.angle));
      check({tag, " quadrant"}, 64'(bus.quadrant), 64'(x.quad));
      check({tag, " error"}, 64'(bus.error), 64'(x.err));
      check({tag, " busy at valid"}, 64'(bus.busy), 64'd0);
    end
  endtask

  task automatic send(input string tag, input logic [63:0] d, input int a, input logic [1:0] q, input logic e);
    expect_res(a, q, e);
    bus.data_in = d;
    bus.en_arccotangent = 1'b1;
    @(negedge clk);
    bus.en_arccotangent = 1'b0;
    bus.data_in = {$urandom, $urandom};
    wait_result(tag, 7);
  endtask

  function automatic logic [63:0] cot_ref(input int k);
    real r;
    r = real'(k) * PI / 180.0;
    return k == 0 ? 64'h7FF0000000000000 : k == 45 ? 64'h3FF0000000000000 : k == 90 ? 64'd0 : $realtobits(1.0 / $tan(r));
  endfunction

  // en stays high: each operand is taken in the DONE cycle of the previous one.
  // below=0 feeds cot(k) (a few ulps high off the exact points) -> k; below=1 feeds just under cot(k) -> k+1, odd k negative.
  task automatic sweep(input bit below);
    logic [63:0] d;
    string tag;
    tag = below ? "below" : "sweep";
    bus.en_arccotangent = 1'b1;
    for (int k = 0; k <= 90 - int'(below); k++) begin
      d = cot_ref(k);
      if (below) begin
        d = d - 64'd64;
        d[63] = 1'(k % 2);
        expect_res(k + 1, 2'(k % 2), 1'b0);
      end else begin
        d = (k % 45 == 0) ? d : d + 64'd8;
        expect_res(k, 2'd0, 1'b0);
      end
      bus.data_in = d;
      @(negedge clk);
      bus.data_in = {$urandom, $urandom};
      wait_result($sformatf("%s k=%0d", tag, k), 7);
    end
    bus.en_arccotangent = 1'b0;
  endtask

  initial begin
    int nv;
    bus.en_arccotangent = 1'b0;
    bus.data_in = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset valid", 64'(bus.valid), 64'd0);
    check("reset error", 64'(bus.error), 64'd0);
    check("reset quadrant", 64'(bus.quadrant), 64'd0);
    check("reset angle", 64'(bus.angle_out), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    send("one", 64'h3FF0000000000000, 45, 2'd0, 1'b0);
    send("neg_one", 64'hBFF0000000000000, 45, 2'd1, 1'b0);
    send("two", 64'h4000000000000000, 27, 2'd0, 1'b0);
    send("p098", $realtobits(0.98), 46, 2'd0, 1'b0);
    send("p100", $realtobits(100.0), 1, 2'd0, 1'b0);
    send("p57", $realtobits(57.0), 2, 2'd0, 1'b0);
    send("p002", $realtobits(0.02), 89, 2'd0, 1'b0);
    send("p001", $realtobits(0.01), 90, 2'd0, 1'b0);
    send("pos_zero", 64'h0000000000000000, 90, 2'd0, 1'b0);
    send("neg_zero", 64'h8000000000000000, 90, 2'd0, 1'b0);
    send("pos_inf", 64'h7FF0000000000000, 0, 2'd0, 1'b0);
    send("neg_inf", 64'hFFF0000000000000, 0, 2'd1, 1'b0);
    send("denorm", 64'h0000000000000001, 90, 2'd0, 1'b0);
    send("neg_denorm", 64'h800FFFFFFFFFFFFF, 90, 2'd1, 1'b0);
    send("qnan", 64'h7FF8000000000000, 0, 2'd0, 1'b1);
    send("after_nan", 64'h3FF0000000000000, 45, 2'd0, 1'b0);
    send("neg_snan", 64'hFFF0000000000001, 0, 2'd0, 1'b1);
    send("max_finite", 64'h7FEFFFFFFFFFFFFF, 1, 2'd0, 1'b0);
    sweep(1'b0);
    sweep(1'b1);
    send("pre_abort", 64'hBFF0000000000000, 45, 2'd1, 1'b0);
    bus.data_in = 64'h4000000000000000;
    bus.en_arccotangent = 1'b1;
    @(negedge clk);
    bus.en_arccotangent = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort valid", 64'(bus.valid), 64'd0);
    check("abort angle", 64'(bus.angle_out), 64'd0);
    check("abort quadrant", 64'(bus.quadrant), 64'd0);
    check("abort error", 64'(bus.error), 64'd0);
    nv = 0;
    repeat (12) begin
      @(negedge clk);
      nv += int'(bus.valid);
    end
    check("abort no valid", 64'(nv), 64'd0);
    expect_res(27, 2'd0, 1'b0);
    bus.data_in = 64'h4000000000000000;
    bus.en_arccotangent = 1'b1;
    @(negedge clk);
    bus.en_arccotangent = 1'b0;
    bus.data_in = 64'h7FF8000000000000;
    @(negedge clk);
    bus.en_arccotangent = 1'b1;
    @(negedge clk);
    bus.en_arccotangent = 1'b0;
    @(negedge clk);
    bus.en_arccotangent = 1'b1;
    @(negedge clk);
    bus.en_arccotangent = 1'b0;
    wait_result("busy_ignore", 3);
    @(negedge clk);
    check("idle after done", 64'(bus.valid), 64'd0);
    check("idle busy", 64'(bus.busy), 64'd0);
    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
